// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared opcode/funct constants, ALU encodings and FSM states
//
// Purpose : common definitions for the fetch/decode front end.
// Ports   : none (package).

package fetch_pkg;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALUctrl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction register contents after reset: addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Front-end FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational decoder for the supported RV32I subset
//
// Purpose : turns one instruction word into execute-stage controls, immediates
//           and register indices, and flags encodings outside the subset.
// Ports   : inst        - instruction word (in)
//           reg_write   - instruction writes rd (out)
//           alu_src     - ALU operand B is the immediate (out)
//           alu_ctrl    - ALU operation (out)
//           result_src  - write-back from memory (out)
//           is_beq      - instruction is beq (out)
//           is_bne      - instruction is bne (out)
//           illegal_hit - encoding not supported (out)
//           imm_i       - sign-extended I-immediate (out)
//           imm_b       - sign-extended B-offset (out)
//           rs1/rs2/rd  - register indices (out)

module instr_decode
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [31:0]              inst,
  output logic                     reg_write,
  output logic                     alu_src,
  output logic [2:0]               alu_ctrl,
  output logic                     result_src,
  output logic                     is_beq,
  output logic                     is_bne,
  output logic                     illegal_hit,
  output logic [DATA_WIDTH-1:0]    imm_i,
  output logic [DATA_WIDTH-1:0]    imm_b,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign rd  = ADDRESS_WIDTH'(inst[11:7]);
  assign rs1 = ADDRESS_WIDTH'(inst[19:15]);
  assign rs2 = ADDRESS_WIDTH'(inst[24:20]);

  assign imm_i = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};

  // Branch offsets are halfword-scaled, so bit 0 is always zero.
  assign imm_b = {{(DATA_WIDTH-13){inst[31]}},
                  inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  // Everything defaults to "illegal, no side effects"; each supported
  // encoding clears illegal_hit and raises only the controls it needs.
  always_comb begin
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    alu_ctrl    = ALU_ADD;
    result_src  = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    illegal_hit = 1'b1;

    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          illegal_hit = 1'b0;
          reg_write   = 1'b1;
          alu_src     = 1'b1;
          alu_ctrl    = ALU_ADD;
        end
      end

      OP_REG: begin
        case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_BASE) begin
              illegal_hit = 1'b0;
              reg_write   = 1'b1;
              alu_ctrl    = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              illegal_hit = 1'b0;
              reg_write   = 1'b1;
              alu_ctrl    = ALU_SUB;
            end
          end
          F3_AND: begin
            if (funct7 == F7_BASE) begin
              illegal_hit = 1'b0;
              reg_write   = 1'b1;
              alu_ctrl    = ALU_AND;
            end
          end
          F3_OR: begin
            if (funct7 == F7_BASE) begin
              illegal_hit = 1'b0;
              reg_write   = 1'b1;
              alu_ctrl    = ALU_OR;
            end
          end
          default: ;
        endcase
      end

      OP_LOAD: begin
        if (funct3 == F3_LW) begin
          illegal_hit = 1'b0;
          reg_write   = 1'b1;
          alu_src     = 1'b1;
          alu_ctrl    = ALU_ADD;
          result_src  = 1'b1;
        end
      end

      OP_BRANCH: begin
        // Branches compare by subtraction; EQ comes back from the ALU.
        if (funct3 == F3_BEQ) begin
          illegal_hit = 1'b0;
          is_beq      = 1'b1;
          alu_ctrl    = ALU_SUB;
        end else if (funct3 == F3_BNE) begin
          illegal_hit = 1'b0;
          is_bne      = 1'b1;
          alu_ctrl    = ALU_SUB;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch FSM with decode and PC sequencing
//
// Purpose : fetches one instruction at a time from instruction memory,
//           presents its decoded fields to the execute stage, and advances
//           the PC (sequential or branch) when execute accepts it.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           imem_req/addr     - fetch request and address (out)
//           imem_ack/rdata    - fetch completion and instruction (in)
//           ex_ready          - execute accepts the issued instruction (in)
//           EQ                - ALU zero flag, used for branch resolution (in)
//           issue_valid       - decoded fields valid (out)
//           RegWrite, ALUsrc,
//           ALUctrl, Resultsrc- execute-stage controls (out)
//           immOp             - sign-extended I-immediate (out)
//           rs1, rs2, rd      - register indices (out)
//           pc                - address of the current instruction (out)
//           illegal           - sticky unsupported-opcode flag (out)

module fetch_decode
  import fetch_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 5,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     ex_ready,
  input  logic                     EQ,
  output logic                     issue_valid,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [2:0]               ALUctrl,
  output logic                     Resultsrc,
  output logic [DATA_WIDTH-1:0]    immOp,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     illegal
);

  state_e                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] ir;
  logic                  illegal_q;

  logic                  dec_reg_write;
  logic                  dec_is_beq;
  logic                  dec_is_bne;
  logic                  dec_illegal;
  logic [DATA_WIDTH-1:0] dec_imm_b;

  logic                  in_issue;
  logic                  taken;
  logic                  retire;
  logic [DATA_WIDTH-1:0] pc_next;

  instr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_decode (
    .inst        (ir[31:0]),
    .reg_write   (dec_reg_write),
    .alu_src     (ALUsrc),
    .alu_ctrl    (ALUctrl),
    .result_src  (Resultsrc),
    .is_beq      (dec_is_beq),
    .is_bne      (dec_is_bne),
    .illegal_hit (dec_illegal),
    .imm_i       (immOp),
    .imm_b       (dec_imm_b),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd)
  );

  assign in_issue = (state == ISSUE);

  // An illegal encoding never looks like a valid issue, even for the one
  // cycle spent in ISSUE before the FSM lands in HALT.
  assign issue_valid = in_issue && !dec_illegal;
  assign retire      = issue_valid && ex_ready;
  assign RegWrite    = retire && dec_reg_write;

  assign taken   = (dec_is_beq && EQ) || (dec_is_bne && !EQ);

  // Plain DATA_WIDTH-bit adds, so the PC wraps naturally at the top of
  // the address space.
  assign pc_next = taken ? (pc_q + dec_imm_b) : (pc_q + DATA_WIDTH'(4));

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      ir        <= DATA_WIDTH'(NOP_INSTR);
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (dec_illegal) begin
            state     <= HALT;
            illegal_q <= 1'b1;
          end else if (ex_ready) begin
            pc_q  <= pc_next;
            state <= FETCH;
          end
        end

        HALT: ;

        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - scoreboard bench for fetch_decode

module tb_fetch_decode;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ex_ready;
  logic        EQ;
  logic        issue_valid;
  logic        RegWrite;
  logic        ALUsrc;
  logic [2:0]  ALUctrl;
  logic        Resultsrc;
  logic [31:0] immOp;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic        illegal;

  fetch_decode #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ex_ready    (ex_ready),
    .EQ          (EQ),
    .issue_valid (issue_valid),
    .RegWrite    (RegWrite),
    .ALUsrc      (ALUsrc),
    .ALUctrl     (ALUctrl),
    .Resultsrc   (Resultsrc),
    .immOp       (immOp),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .pc          (pc),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        result_src;
    logic        reg_write;
    logic [31:0] imm;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic asrc, input logic [2:0] actl,
                              input logic rsrc, input logic rw, input logic [31:0] im);
    exp_t e;
    e.pc = p; e.rd = d; e.rs1 = s1; e.rs2 = s2; e.alu_src = asrc;
    e.alu_ctrl = actl; e.result_src = rsrc; e.reg_write = rw; e.imm = im;
    return e;
  endfunction

  // Monitor: compares every fetch handshake and every issue handshake
  // against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (imem_req && imem_ack) begin
        if (addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, addr_q.pop_front());
        end
      end
      if (issue_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexpected: got pc %h expected no issue", pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_pc", pc, e.pc);
          check("issue_imm", immOp, e.imm);
          check("issue_fields",
                {11'd0, rd, rs1, rs2, ALUsrc, ALUctrl, Resultsrc, RegWrite},
                {11'd0, e.rd, e.rs1, e.rs2, e.alu_src, e.alu_ctrl, e.result_src, e.reg_write});
        end
      end
    end
  end

  // Called just after a rising edge with the DUT in FETCH.
  task automatic do_fetch(input logic [31:0] inst, input int waits, input logic [31:0] addr);
    addr_q.push_back(addr);
    imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("fetch_wait_req", {31'd0, imem_req}, 32'd1);
      check("fetch_wait_addr", imem_addr, addr);
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = inst;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Called just after the edge that accepted the fetch (DUT in ISSUE).
  task automatic do_issue(input exp_t e, input int stall, input logic eq);
    exp_q.push_back(e);
    EQ       = eq;
    ex_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, issue_valid}, 32'd1);
      check("stall_regwrite", {31'd0, RegWrite}, 32'd0);
      check("stall_pc", pc, e.pc);
      check("stall_imm", immOp, e.imm);
      check("stall_rd", {27'd0, rd}, {27'd0, e.rd});
      @(posedge clk); #1;
      if (i == stall - 1) ex_ready = 1'b1;
    end
    @(negedge clk);
    @(posedge clk); #1;
    ex_ready = 1'b0;
    EQ       = 1'b0;
    @(negedge clk);
    check("regwrite_pulse", {31'd0, RegWrite}, 32'd0);
    check("issue_dropped", {31'd0, issue_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    ex_ready   = 1'b0;
    EQ         = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd1);
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // addi x1,x0,5 with three wait cycles
    do_fetch(32'h0050_0093, 3, 32'h0);
    do_issue(mk(32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 3'b000, 1'b0, 1'b1, 32'd5), 0, 1'b0);
    // add x3,x1,x2 with execute stalled 4 cycles
    do_fetch(32'h0020_81B3, 0, 32'h4);
    do_issue(mk(32'h4, 5'd3, 5'd1, 5'd2, 1'b0, 3'b000, 1'b0, 1'b1, 32'd2), 4, 1'b0);
    // sub x5,x3,x4
    do_fetch(32'h4041_82B3, 1, 32'h8);
    do_issue(mk(32'h8, 5'd5, 5'd3, 5'd4, 1'b0, 3'b001, 1'b0, 1'b1, 32'h404), 0, 1'b0);
    // lw x6,-4(x2)
    do_fetch(32'hFFC1_2303, 0, 32'hC);
    do_issue(mk(32'hC, 5'd6, 5'd2, 5'd28, 1'b1, 3'b000, 1'b1, 1'b1, 32'hFFFF_FFFC), 0, 1'b0);
    // beq -8 at 0x10, taken -> 0x08
    do_fetch(32'hFE20_8CE3, 0, 32'h10);
    do_issue(mk(32'h10, 5'd25, 5'd1, 5'd2, 1'b0, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFE2), 0, 1'b1);
    // bne -8 at 0x08 with EQ=1, not taken -> 0x0C
    do_fetch(32'hFE20_9CE3, 0, 32'h8);
    do_issue(mk(32'h8, 5'd25, 5'd1, 5'd2, 1'b0, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFE2), 0, 1'b1);
    // nop at 0x0C -> 0x10
    do_fetch(32'h0000_0013, 0, 32'hC);
    do_issue(mk(32'hC, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 1'b0, 1'b1, 32'd0), 0, 1'b0);
    // beq -8 at 0x10 with EQ=0, not taken -> 0x14
    do_fetch(32'hFE20_8CE3, 0, 32'h10);
    do_issue(mk(32'h10, 5'd25, 5'd1, 5'd2, 1'b0, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFE2), 0, 1'b0);
    // beq -24 at 0x14, taken -> 0xFFFF_FFFC
    do_fetch(32'hFE20_84E3, 0, 32'h14);
    do_issue(mk(32'h14, 5'd9, 5'd1, 5'd2, 1'b0, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFE2), 0, 1'b1);
    // addi at 0xFFFF_FFFC wraps to 0
    do_fetch(32'h0050_0093, 0, 32'hFFFF_FFFC);
    do_issue(mk(32'hFFFF_FFFC, 5'd1, 5'd0, 5'd5, 1'b1, 3'b000, 1'b0, 1'b1, 32'd5), 0, 1'b0);
    // and x7,x1,x2 at 0
    do_fetch(32'h0020_F3B3, 0, 32'h0);
    do_issue(mk(32'h0, 5'd7, 5'd1, 5'd2, 1'b0, 3'b010, 1'b0, 1'b1, 32'd2), 0, 1'b0);
    // or x7,x1,x2 at 4
    do_fetch(32'h0020_E3B3, 0, 32'h4);
    do_issue(mk(32'h4, 5'd7, 5'd1, 5'd2, 1'b0, 3'b011, 1'b0, 1'b1, 32'd2), 0, 1'b0);

    // unsupported opcode at 0x08 -> HALT
    do_fetch(32'h0000_007F, 0, 32'h8);
    ex_ready = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    check("illegal_no_issue", {31'd0, issue_valid}, 32'd0);
    check("illegal_no_regwrite", {31'd0, RegWrite}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_illegal", {31'd0, illegal}, 32'd1);
      check("halt_imem_req", {31'd0, imem_req}, 32'd0);
      check("halt_issue_valid", {31'd0, issue_valid}, 32'd0);
      @(posedge clk); #1;
    end
    ex_ready = 1'b0;
    imem_ack = 1'b0;

    // reset out of HALT
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("halt_rst_illegal", {31'd0, illegal}, 32'd0);
    check("halt_rst_imem_req", {31'd0, imem_req}, 32'd1);
    check("halt_rst_pc", pc, 32'h0);
    @(posedge clk); #1;

    do_fetch(32'h0050_0093, 0, 32'h0);
    do_issue(mk(32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 3'b000, 1'b0, 1'b1, 32'd5), 0, 1'b0);

    // reset coinciding with an ack at pc=4: fetch is abandoned
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(posedge clk); #1;
    rst        = 1'b0;
    imem_ack   = 1'b0;
    @(negedge clk);
    check("rstack_pc", pc, 32'h0);
    check("rstack_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rstack_imem_req", {31'd0, imem_req}, 32'd1);
    check("rstack_imem_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstack_still_fetch", {31'd0, issue_valid}, 32'd0);
    @(posedge clk); #1;

    do_fetch(32'h0020_81B3, 1, 32'h0);
    do_issue(mk(32'h0, 5'd3, 5'd1, 5'd2, 1'b0, 3'b000, 1'b0, 1'b1, 32'd2), 0, 1'b0);

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("addr_q_drained", addr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
